// File: rtl/lab4_net_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab4_net_router_pkg
// Description : Shared definitions for the ring router. Holds the direction
//               bit positions, the 3-bit one-hot request type and the
//               shortest-path route function used by the input units.
// Revision    : 1.0 - initial release
// ============================================================================
package lab4_net_router_pkg;

    // Bit positions inside a request / grant vector
    localparam int EAST = 0;
    localparam int TERM = 1;
    localparam int WEST = 2;

    typedef logic [2:0] req_t;

    // Eastward and westward hop counts around the ring. A negative raw
    // difference is corrected by adding the ring size.
    function automatic int dist_east(input int dest, input int id, input int num_routers);
        int d;
        d = dest - id;
        if (d < 0) d = d + num_routers;
        return d;
    endfunction

    function automatic int dist_west(input int dest, input int id, input int num_routers);
        int d;
        d = id - dest;
        if (d < 0) d = d + num_routers;
        return d;
    endfunction

    // True when the destination is exactly half way round an even ring.
    function automatic logic route_is_tie(input int dest, input int id, input int num_routers);
        int de;
        int dw;
        de = dist_east(dest, id, num_routers);
        dw = dist_west(dest, id, num_routers);
        return (de != 0) && (de == dw);
    endfunction

    // One-hot shortest-path route. Equidistant destinations go east when
    // tie is 0 and west when tie is 1.
    function automatic req_t route_req(input int dest, input int id,
                                       input int num_routers, input logic tie);
        int   de;
        int   dw;
        req_t r;
        de = dist_east(dest, id, num_routers);
        dw = dist_west(dest, id, num_routers);
        r  = '0;
        if (de == 0)      r[TERM] = 1'b1;
        else if (de < dw) r[EAST] = 1'b1;
        else if (dw < de) r[WEST] = 1'b1;
        else if (tie)     r[WEST] = 1'b1;
        else              r[EAST] = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lab4_net_router_input_queue.sv
`default_nettype none
// ============================================================================
// Module      : lab4_net_router_input_queue
// Description : Circular FIFO of NUM_ENTRIES messages without bypass. The
//               depth need not be a power of two; pointers wrap explicitly.
//   clk, reset : clock and synchronous active-high reset
//   enq_val    : enqueue request, enq_msg is the data
//   enq_rdy    : queue not full
//   deq_en     : pop the head (ignored when empty)
//   deq_msg    : head message, zero when empty
//   count      : current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module lab4_net_router_input_queue #(
    parameter  int MSG_NBITS   = 32,
    parameter  int NUM_ENTRIES = 2,
    localparam int CNT_NBITS   = $clog2(NUM_ENTRIES + 1),
    localparam int PTR_NBITS   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq_val,
    input  logic [MSG_NBITS-1:0] enq_msg,
    output logic                 enq_rdy,
    input  logic                 deq_en,
    output logic [MSG_NBITS-1:0] deq_msg,
    output logic [CNT_NBITS-1:0] count
);

    logic [MSG_NBITS-1:0] r_mem [NUM_ENTRIES];
    logic [PTR_NBITS-1:0] r_head;
    logic [PTR_NBITS-1:0] r_tail;
    logic [CNT_NBITS-1:0] r_count;
    logic                 w_enq;
    logic                 w_deq;

    function automatic logic [PTR_NBITS-1:0] next_ptr(input logic [PTR_NBITS-1:0] p);
        if (p == PTR_NBITS'(NUM_ENTRIES - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign enq_rdy = (r_count != CNT_NBITS'(NUM_ENTRIES));
    assign w_enq   = enq_val && enq_rdy;
    assign w_deq   = deq_en && (r_count != '0);
    assign count   = r_count;
    // Zero when empty so the head never shows stale data.
    assign deq_msg = (r_count != '0) ? r_mem[r_head] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) r_mem[i] <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail] <= enq_msg;
                r_tail        <= next_ptr(r_tail);
            end
            if (w_deq) r_head <= next_ptr(r_head);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_NBITS'(1);
                2'b01:   r_count <= r_count - CNT_NBITS'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lab4_net_router_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : lab4_net_router_input_unit
// Description : Buffered input unit for one ring-router port. Queues incoming
//               messages, routes the head along the shortest ring path
//               (east / terminal / west, with wrap-around) and dequeues it
//               on a matching grant. Equidistant destinations alternate
//               between east and west using a tie bit.
//   clk, reset : clock and synchronous active-high reset
//   in_msg     : incoming message, in_val qualifies it, in_rdy accepts it
//   out_msg    : head-of-queue message to the crossbar
//   reqs       : one-hot request, bit0 east, bit1 terminal, bit2 west
//   grants     : one-hot grant from the output arbiters, same order
//   count      : queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module lab4_net_router_input_unit
    import lab4_net_router_pkg::*;
#(
    parameter  int p_router_id   = 0,
    parameter  int p_num_routers = 8,
    parameter  int p_msg_nbits   = 32,
    parameter  int p_num_entries = 2,
    localparam int c_dest_nbits  = $clog2(p_num_routers),
    localparam int c_cnt_nbits   = $clog2(p_num_entries + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_msg_nbits-1:0] in_msg,
    input  logic                   in_val,
    output logic                   in_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic [2:0]             reqs,
    input  logic [2:0]             grants,
    output logic [c_cnt_nbits-1:0] count
);

    logic [c_dest_nbits-1:0] w_dest;
    req_t                    w_route;
    logic                    w_tie_route;
    logic                    w_deq;
    logic                    r_tie;

    lab4_net_router_input_queue #(
        .MSG_NBITS   (p_msg_nbits),
        .NUM_ENTRIES (p_num_entries)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (in_val),
        .enq_msg (in_msg),
        .enq_rdy (in_rdy),
        .deq_en  (w_deq),
        .deq_msg (out_msg),
        .count   (count)
    );

    assign w_dest      = out_msg[p_msg_nbits-1 -: c_dest_nbits];
    assign w_route     = route_req(int'(w_dest), p_router_id, p_num_routers, r_tie);
    assign w_tie_route = route_is_tie(int'(w_dest), p_router_id, p_num_routers);

    // The head only changes on dequeue and the tie bit only flips on
    // dequeue, so reqs holds steady from assertion until grant.
    assign reqs  = (count != '0) ? w_route : 3'b000;
    // Grant bits that do not match the request are ignored.
    assign w_deq = (count != '0) && ((grants & reqs) != 3'b000);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tie <= 1'b0;
        end else if (w_deq && w_tie_route) begin
            r_tie <= ~r_tie;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab4_net_router_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab4_net_router_input_unit
// Description : Self-checking bench for lab4_net_router_input_unit. One
//               instance with N=8/id=2 and one with N=5/id=4, both depth 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab4_net_router_input_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_msg, out_msg, in_msg2, out_msg2;
    logic        in_val, in_rdy, in_val2, in_rdy2;
    logic [2:0]  reqs, grants, reqs2, grants2;
    logic [1:0]  count, count2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] msg;
        logic [2:0]  reqs;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lab4_net_router_input_unit #(
        .p_router_id(2), .p_num_routers(8), .p_msg_nbits(32), .p_num_entries(2)
    ) dut (
        .clk(clk), .reset(reset), .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
        .out_msg(out_msg), .reqs(reqs), .grants(grants), .count(count)
    );

    lab4_net_router_input_unit #(
        .p_router_id(4), .p_num_routers(5), .p_msg_nbits(32), .p_num_entries(2)
    ) dut5 (
        .clk(clk), .reset(reset), .in_msg(in_msg2), .in_val(in_val2), .in_rdy(in_rdy2),
        .out_msg(out_msg2), .reqs(reqs2), .grants(grants2), .count(count2)
    );

    function automatic logic [31:0] mk(input int dest, input int pay);
        logic [2:0] d;
        d = 3'(dest);
        return {d, 29'(pay)};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; in_val = 1'b0; grants = 3'b000; in_val2 = 1'b0; grants2 = 3'b000;
        in_msg = '0; in_msg2 = '0;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (in_rdy !== 1'b1 || reqs !== 3'b000 || out_msg !== 32'd0 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_n8: in_rdy=%b reqs=%b out_msg=%h count=%0d, need 1 000 0 0",
                     in_rdy, reqs, out_msg, count);
        end
        n_checks++;
        if (in_rdy2 !== 1'b1 || reqs2 !== 3'b000 || out_msg2 !== 32'd0 || count2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_n5: in_rdy=%b reqs=%b out_msg=%h count=%0d, need 1 000 0 0",
                     in_rdy2, reqs2, out_msg2, count2);
        end
    endtask

    // Stream four messages with matching grants; each head is popped from
    // the scoreboard and compared as it is presented.
    task automatic test_routing();
        int         dests[4] = '{2, 5, 7, 0};
        logic [2:0] exp_r[4] = '{3'b010, 3'b001, 3'b100, 3'b100};
        int   idx = 0;
        int   cyc = 0;
        exp_t e, h;
        apply_reset();
        while ((idx < 4 || sb.size() != 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            grants = 3'b000;
            if (reqs != 3'b000) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL routing_unexpected: reqs=%b with nothing outstanding", reqs);
                end else begin
                    h = sb.pop_front();
                    if (reqs !== h.reqs || out_msg !== h.msg) begin
                        n_fail++;
                        $display("FAIL routing_head: reqs=%b msg=%h, need reqs=%b msg=%h",
                                 reqs, out_msg, h.reqs, h.msg);
                    end
                    grants = h.reqs;
                end
            end
            if (idx < 4) begin
                in_val = 1'b1;
                in_msg = mk(dests[idx], 100 + idx);
                if (in_rdy) begin
                    e.msg = in_msg; e.reqs = exp_r[idx];
                    sb.push_back(e);
                    idx++;
                end
            end else begin
                in_val = 1'b0;
            end
        end
        @(negedge clk);
        grants = 3'b000; in_val = 1'b0;
        n_checks++;
        if (cyc >= 40 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL routing_drain: cycles=%0d count=%0d, need <40 and 0", cyc, count);
        end
    endtask

    // Three messages to the opposite side of the ring alternate east/west.
    task automatic test_tie();
        logic [2:0] exp_r[3] = '{3'b001, 3'b100, 3'b001};
        int   idx = 0;
        int   cyc = 0;
        exp_t e, h;
        apply_reset();
        while ((idx < 3 || sb.size() != 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            grants = 3'b000;
            if (reqs != 3'b000) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL tie_unexpected: reqs=%b with nothing outstanding", reqs);
                end else begin
                    h = sb.pop_front();
                    if (reqs !== h.reqs || out_msg !== h.msg) begin
                        n_fail++;
                        $display("FAIL tie_head: reqs=%b msg=%h, need reqs=%b msg=%h",
                                 reqs, out_msg, h.reqs, h.msg);
                    end
                    grants = h.reqs;
                end
            end
            if (idx < 3) begin
                in_val = 1'b1;
                in_msg = mk(6, 200 + idx);
                if (in_rdy) begin
                    e.msg = in_msg; e.reqs = exp_r[idx];
                    sb.push_back(e);
                    idx++;
                end
            end else begin
                in_val = 1'b0;
            end
        end
        @(negedge clk);
        grants = 3'b000; in_val = 1'b0;
        n_checks++;
        if (cyc >= 40 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL tie_drain: cycles=%0d count=%0d, need <40 and 0", cyc, count);
        end
    endtask

    task automatic test_full();
        logic [31:0] m1, m2, m3;
        m1 = mk(5, 301); m2 = mk(7, 302); m3 = mk(2, 303);
        apply_reset();
        in_val = 1'b1; in_msg = m1;
        @(negedge clk);
        n_checks++;
        if (in_rdy !== 1'b1 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL full_first: in_rdy=%b count=%0d, need 1 1", in_rdy, count);
        end
        in_msg = m2;
        @(negedge clk);
        in_msg = m3;
        n_checks++;
        if (in_rdy !== 1'b0 || count !== 2'd2 || out_msg !== m1 || reqs !== 3'b001) begin
            n_fail++;
            $display("FAIL full_state: in_rdy=%b count=%0d msg=%h reqs=%b, need 0 2 %h 001",
                     in_rdy, count, out_msg, reqs, m1);
        end
        grants = 3'b001;
        @(negedge clk);
        grants = 3'b000;
        n_checks++;
        if (in_rdy !== 1'b1 || count !== 2'd1 || out_msg !== m2 || reqs !== 3'b100) begin
            n_fail++;
            $display("FAIL full_after_grant: in_rdy=%b count=%0d msg=%h reqs=%b, need 1 1 %h 100",
                     in_rdy, count, out_msg, reqs, m2);
        end
        @(negedge clk);
        in_val = 1'b0;
        n_checks++;
        if (in_rdy !== 1'b0 || count !== 2'd2) begin
            n_fail++;
            $display("FAIL full_refill: in_rdy=%b count=%0d, need 0 2", in_rdy, count);
        end
    endtask

    task automatic test_wrong_grant();
        logic [31:0] m;
        m = mk(5, 401);
        apply_reset();
        in_val = 1'b1; in_msg = m;
        @(negedge clk);
        in_val = 1'b0;
        grants = 3'b100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (reqs !== 3'b001 || out_msg !== m || count !== 2'd1) begin
                n_fail++;
                $display("FAIL wrong_grant[%0d]: reqs=%b msg=%h count=%0d, need 001 %h 1",
                         i, reqs, out_msg, count, m);
            end
        end
        grants = 3'b001;
        @(negedge clk);
        grants = 3'b000;
        n_checks++;
        if (count !== 2'd0 || reqs !== 3'b000) begin
            n_fail++;
            $display("FAIL wrong_grant_clear: count=%0d reqs=%b, need 0 000", count, reqs);
        end
    endtask

    // N=5, id=4: dest 1 wraps east through router 0, dest 3 is one hop west.
    task automatic test_wrap_n5();
        int         dests[4] = '{1, 0, 3, 4};
        logic [2:0] exp_r[4] = '{3'b001, 3'b001, 3'b100, 3'b010};
        exp_t e, h;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_val2 = 1'b1; in_msg2 = mk(dests[i], 500 + i);
            e.msg = in_msg2; e.reqs = exp_r[i];
            sb.push_back(e);
            @(negedge clk);
            in_val2 = 1'b0;
            h = sb.pop_front();
            n_checks++;
            if (reqs2 !== h.reqs || out_msg2 !== h.msg) begin
                n_fail++;
                $display("FAIL wrap_n5 dest=%0d: reqs=%b msg=%h, need %b %h",
                         dests[i], reqs2, out_msg2, h.reqs, h.msg);
            end
            grants2 = h.reqs;
            @(negedge clk);
            grants2 = 3'b000;
        end
        n_checks++;
        if (count2 !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_n5_drain: count=%0d, need 0", count2);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        // A tie dequeue sets the tie bit to 1.
        in_val = 1'b1; in_msg = mk(6, 601);
        @(negedge clk);
        in_val = 1'b0; grants = 3'b001;
        @(negedge clk);
        grants = 3'b000;
        in_val = 1'b1; in_msg = mk(6, 602);
        @(negedge clk);
        in_msg = mk(5, 603);
        n_checks++;
        if (reqs !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_tie_set: reqs=%b, need 100", reqs);
        end
        @(negedge clk);
        in_val = 1'b0;
        n_checks++;
        if (count !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_mid_fill: count=%0d, need 2", count);
        end
        reset = 1'b1; in_val = 1'b1; in_msg = mk(7, 604); grants = 3'b100;
        @(negedge clk);
        reset = 1'b0; in_val = 1'b0; grants = 3'b000;
        n_checks++;
        if (count !== 2'd0 || reqs !== 3'b000 || in_rdy !== 1'b1 || out_msg !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: count=%0d reqs=%b in_rdy=%b msg=%h, need 0 000 1 0",
                     count, reqs, in_rdy, out_msg);
        end
        in_val = 1'b1; in_msg = mk(6, 605);
        @(negedge clk);
        in_val = 1'b0;
        n_checks++;
        if (reqs !== 3'b001 || out_msg !== mk(6, 605)) begin
            n_fail++;
            $display("FAIL reset_mid_tie_cleared: reqs=%b msg=%h, need 001 %h",
                     reqs, out_msg, mk(6, 605));
        end
        grants = 3'b001;
        @(negedge clk);
        grants = 3'b000;
    endtask

    initial begin
        reset = 1'b1; in_val = 1'b0; in_val2 = 1'b0; grants = 3'b000; grants2 = 3'b000;
        in_msg = '0; in_msg2 = '0;
        test_reset();
        test_routing();
        test_tie();
        test_full();
        test_wrong_grant();
        test_wrap_n5();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
